// File: rtl/blade_cfg_pkg.sv
// Shared encodings and helpers for the blade configuration bank.
package blade_cfg_pkg;

  // Per-channel update operations carried on the command bus.
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_INV  = 2'b11
  } op_e;

  // Control FSM: single-channel commands in IDLE, broadcast walk in SWEEP.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // Channel-index width; at least one bit so a single-channel bank still has a port.
  function automatic int ch_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/blade_config_bank_if.sv
// Command bus into the blade configuration bank (valid/ready handshake).
interface blade_config_bank_if
  import blade_cfg_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 2
) ();

  localparam int CH_BITS = ch_bits(CHANNELS);

  logic               cmd_valid;
  logic               cmd_ready;
  op_e                cmd_op;
  logic [CH_BITS-1:0] cmd_ch;
  logic               cmd_all;
  logic [WIDTH-1:0]   cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_all, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_all, cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/blade_cfg_step.sv
// Next-value function for one channel config: load, wrap-around step, or invert.
module blade_cfg_step
  import blade_cfg_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] x,
  input  op_e              op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] y
);

  // Modular WIDTH-bit arithmetic gives the required wrap at both ends for free.
  always_comb begin
    // NOTE: assigning a default before the case means no path leaves y unassigned, so no latch is inferred.
    y = x;
    case (op)
      OP_LOAD: y = data;
      OP_INC:  y = x + WIDTH'(1);
      OP_DEC:  y = x - WIDTH'(1);
      OP_INV:  y = ~x;
      default: y = x;
    endcase
  end

endmodule

// File: rtl/blade_config_bank.sv
// Bank of CHANNELS blade configs, updated per channel or by a broadcast sweep
// that walks one channel per cycle using a single shared update port.
module blade_config_bank
  import blade_cfg_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  blade_config_bank_if.slave        bus,
  output logic [CHANNELS*WIDTH-1:0] cfg_out,
  output logic                      busy,
  output logic                      sweep_done
);

  localparam int                 CH_BITS = ch_bits(CHANNELS);
  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(CHANNELS - 1);

  state_e             state, state_nxt;
  logic [CH_BITS-1:0] idx;
  op_e                op_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   cfg [CHANNELS];
  logic               done_q;

  logic               accept;
  logic               in_range;
  logic               wr_en;
  logic [CH_BITS-1:0] wr_idx;
  op_e                wr_op;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   wr_cur;
  logic [WIDTH-1:0]   wr_new;

  // Ready is a function of state alone, so accept is derived from state directly.
  assign accept   = bus.cmd_valid && (state == ST_IDLE);
  assign in_range = ({1'b0, bus.cmd_ch} < (CH_BITS + 1)'(CHANNELS));

  // FSM next state and handshake/status outputs.
  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    busy          = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (accept && bus.cmd_all) state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        busy = 1'b1;
        if (idx == LAST_CH) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Single write port: the sweep owns it while active, otherwise the host command does.
  always_comb begin
    wr_idx  = bus.cmd_ch;
    wr_op   = bus.cmd_op;
    wr_data = bus.cmd_data;
    wr_en   = accept && !bus.cmd_all && in_range;
    if (state == ST_SWEEP) begin
      wr_idx  = idx;
      wr_op   = op_q;
      wr_data = data_q;
      wr_en   = 1'b1;
    end
  end

  // Read the current value of the addressed channel; out-of-range indices read zero.
  always_comb begin
    wr_cur = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_idx == CH_BITS'(c)) wr_cur = cfg[c];
    end
  end

  blade_cfg_step #(.WIDTH(WIDTH)) u_step (
    .x    (wr_cur),
    .op   (wr_op),
    .data (wr_data),
    .y    (wr_new)
  );

  // Sweep bookkeeping, done pulse and the channel register array.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      op_q   <= OP_LOAD;
      data_q <= '0;
      done_q <= 1'b0;
      // NOTE: the config array is architecturally visible downstream, so every entry is reset, not just the control state.
      for (int c = 0; c < CHANNELS; c++) cfg[c] <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
      done_q <= (state == ST_SWEEP) && (idx == LAST_CH);
      if (accept && bus.cmd_all) begin
        op_q   <= bus.cmd_op;
        data_q <= bus.cmd_data;
        idx    <= '0;
      end else if (state == ST_SWEEP) begin
        idx <= (idx == LAST_CH) ? '0 : idx + CH_BITS'(1);
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_en && (wr_idx == CH_BITS'(c))) cfg[c] <= wr_new;
      end
    end
  end

  // Flatten the register array onto the output bus.
  always_comb begin
    cfg_out = '0;
    for (int c = 0; c < CHANNELS; c++) cfg_out[c*WIDTH +: WIDTH] = cfg[c];
  end

  assign sweep_done = done_q;

endmodule

// File: tb/tb_blade_config_bank.sv
// Bench for blade_config_bank: a 4-channel and a 3-channel instance share one
// stimulus stream; a per-cycle behavioural model checks both, and directed
// sequences pin the model with hand-computed values.
module tb_blade_config_bank;
  import blade_cfg_pkg::*;

  localparam int MAXV = 4;  // 2^WIDTH with WIDTH = 2

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [1:0] op;
  logic [1:0] ch;
  logic       all;
  logic [1:0] data;

  logic [7:0] cfg4;
  logic [5:0] cfg3;
  logic       busy4, busy3, done4, done3;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  blade_config_bank_if #(.CHANNELS(4), .WIDTH(2)) bus4 ();
  blade_config_bank_if #(.CHANNELS(3), .WIDTH(2)) bus3 ();

  assign bus4.cmd_valid = valid;
  assign bus4.cmd_op    = op_e'(op);
  assign bus4.cmd_ch    = ch;
  assign bus4.cmd_all   = all;
  assign bus4.cmd_data  = data;
  assign bus3.cmd_valid = valid;
  assign bus3.cmd_op    = op_e'(op);
  assign bus3.cmd_ch    = ch;
  assign bus3.cmd_all   = all;
  assign bus3.cmd_data  = data;

  blade_config_bank #(.CHANNELS(4), .WIDTH(2)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus4.slave),
    .cfg_out    (cfg4),
    .busy       (busy4),
    .sweep_done (done4)
  );

  blade_config_bank #(.CHANNELS(3), .WIDTH(2)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus3.slave),
    .cfg_out    (cfg3),
    .busy       (busy3),
    .sweep_done (done3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance: channel values, number of sweep writes still owed, the next
  // channel the sweep will write, the latched sweep command and the done flag.
  int nch [2] = '{4, 3};
  int m_cfg [2][4];
  int m_pend [2];
  int m_next [2];
  int m_op [2];
  int m_data [2];
  bit m_done [2];
  bit model_on = 1'b0;

  function automatic int f(input int fop, input int x, input int d);
    case (fop)
      0:       return d;
      1:       return (x + 1) % MAXV;
      2:       return (x + MAXV - 1) % MAXV;
      default: return (MAXV - 1) - x;
    endcase
  endfunction

  function automatic logic [7:0] pack(input int d);
    logic [7:0] r = '0;
    for (int c = 0; c < nch[d]; c++) r |= 8'(m_cfg[d][c]) << (2 * c);
    return r;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int c = 0; c < 4; c++) m_cfg[d][c] = 0;
        m_pend[d] = 0;
        m_next[d] = 0;
        m_done[d] = 1'b0;
      end else begin
        m_done[d] = 1'b0;
        if (m_pend[d] > 0) begin
          m_cfg[d][m_next[d]] = f(m_op[d], m_cfg[d][m_next[d]], m_data[d]);
          m_next[d]++;
          m_pend[d]--;
          if (m_pend[d] == 0) m_done[d] = 1'b1;
        end else if (valid) begin
          if (all) begin
            m_op[d]   = int'(op);
            m_data[d] = int'(data);
            m_pend[d] = nch[d];
            m_next[d] = 0;
          end else if (int'(ch) < nch[d]) begin
            m_cfg[d][ch] = f(int'(op), m_cfg[d][ch], int'(data));
          end
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("dut4 cfg_out",    32'(cfg4),           32'(pack(0)));
      check("dut4 busy",       32'(busy4),          32'(m_pend[0] > 0));
      check("dut4 cmd_ready",  32'(bus4.cmd_ready), 32'(m_pend[0] == 0));
      check("dut4 sweep_done", 32'(done4),          32'(m_done[0]));
      check("dut3 cfg_out",    32'(cfg3),           32'(pack(1)));
      check("dut3 busy",       32'(busy3),          32'(m_pend[1] > 0));
      check("dut3 cmd_ready",  32'(bus3.cmd_ready), 32'(m_pend[1] == 0));
      check("dut3 sweep_done", 32'(done3),          32'(m_done[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [1:0] c, input logic a, input logic [1:0] d);
    valid = 1'b1; op = o; ch = c; all = a; data = d;
    cycle();
    valid = 1'b0;
  endtask

  initial begin
    int busy_cnt;

    // Reset with a command pending: nothing may be applied.
    rst = 1'b1; valid = 1'b1; op = 2'd1; ch = 2'd2; all = 1'b0; data = 2'd3;
    repeat (2) cycle();
    check("reset cfg_out",    32'(cfg4),           32'h00);
    check("reset cmd_ready",  32'(bus4.cmd_ready), 32'h1);
    check("reset busy",       32'(busy4),          32'h0);
    check("reset sweep_done", 32'(done4),          32'h0);
    rst = 1'b0; valid = 1'b0;
    model_on = 1'b1;

    // Single-channel ops on ch2.
    issue(2'd0, 2'd2, 1'b0, 2'd3);
    check("load ch2", 32'(cfg4), 32'h30);
    issue(2'd1, 2'd2, 1'b0, 2'd0);
    check("inc ch2 wrap", 32'(cfg4), 32'h00);
    issue(2'd2, 2'd2, 1'b0, 2'd0);
    check("dec ch2 wrap", 32'(cfg4), 32'h30);
    issue(2'd3, 2'd2, 1'b0, 2'd0);
    check("inv ch2", 32'(cfg4), 32'h00);

    // Broadcast INC with a LOAD ch1 held off behind it; the held op flickers mid-sweep.
    issue(2'd1, 2'd0, 1'b1, 2'd0);
    valid = 1'b1; op = 2'd0; ch = 2'd1; all = 1'b0; data = 2'd2;
    busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (!busy4) break;
      busy_cnt++;
      check("sweep cmd_ready", 32'(bus4.cmd_ready), 32'h0);
      if (k == 1) op = 2'd3;
      if (k == 2) op = 2'd0;
      cycle();
    end
    check("sweep busy cycles", 32'(busy_cnt), 32'd4);
    check("sweep result",      32'(cfg4), 32'h55);
    check("sweep done pulse",  32'(done4), 32'h1);
    check("done-cycle ready",  32'(bus4.cmd_ready), 32'h1);
    cycle();
    valid = 1'b0;
    check("held load applied", 32'(cfg4), 32'h59);
    check("done one cycle",    32'(done4), 32'h0);

    // Reset aborts a broadcast LOAD after two channels.
    issue(2'd0, 2'd0, 1'b1, 2'd3);
    cycle();
    cycle();
    check("partial sweep", 32'(cfg4), 32'h5F);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort cfg_out", 32'(cfg4), 32'h00);
    check("abort busy",    32'(busy4), 32'h0);
    check("abort no done", 32'(done4), 32'h0);
    cycle();
    check("abort no done later", 32'(done4), 32'h0);

    // Out-of-range channel on the 3-channel bank.
    issue(2'd0, 2'd0, 1'b0, 2'd2);
    check("dut3 load ch0", 32'(cfg3), 32'h02);
    issue(2'd0, 2'd3, 1'b0, 2'd1);
    check("dut3 oob unchanged", 32'(cfg3), 32'h02);
    check("dut3 oob ready",     32'(bus3.cmd_ready), 32'h1);

    // Randomised traffic, including occasional resets and broadcasts.
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      valid = ($urandom_range(0, 9) < 7);
      op    = 2'($urandom_range(0, 3));
      ch    = 2'($urandom_range(0, 3));
      all   = ($urandom_range(0, 5) == 0);
      data  = 2'($urandom_range(0, 3));
      cycle();
    end
    rst = 1'b0; valid = 1'b0;
    repeat (6) cycle();

    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
